// File: rtl/multdiv_unit_if.sv
// Execute-stage handshake between pipeline control and the multicycle multiply/divide unit.
// Pipeline drives operands and one-cycle start pulses; the unit returns result, exception, ready pulse and busy.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Signed multicycle multiply (shift-add) / divide (restoring), one bit per cycle on magnitudes.
// Latency WIDTH+1 edges to the ready pulse (1 for divide-by-zero); starts while iterating are ignored.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_unit_if.slave  mdu
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, lo, mcand;
  logic             neg, is_div, div_zero;

  logic             start_ok, start_mul, start_div, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_shift, div_diff;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH:0]   prod_hi;

  logic             busy_nxt, rdy_nxt, exc_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             busy_q, rdy_q, exc_q;
  logic [WIDTH-1:0] result_q;

  assign start_ok  = (state == IDLE) || (state == DONE);
  assign start_mul = start_ok && mdu.ctrl_MULT;
  assign start_div = start_ok && mdu.ctrl_DIV && !mdu.ctrl_MULT;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign a_mag = mdu.data_operandA[WIDTH-1] ? -mdu.data_operandA : mdu.data_operandA;
  assign b_mag = mdu.data_operandB[WIDTH-1] ? -mdu.data_operandB : mdu.data_operandB;

  assign mul_sum   = {1'b0, acc} + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
  assign rem_shift = {acc, lo[WIDTH-1]};
  assign div_diff  = rem_shift - {1'b0, mcand};

  assign prod    = {acc, lo};
  assign sprod   = neg ? -prod : prod;
  assign prod_hi = sprod[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start_mul)      state_nxt = MULT;
        else if (start_div) state_nxt = (mdu.data_operandB == '0) ? DONE : DIV;
      end
      MULT, DIV: if (last_iter) state_nxt = DONE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are registered one cycle behind the state, so RDY follows the DONE cycle.
  always_comb begin
    busy_nxt   = (state == MULT) || (state == DIV);
    rdy_nxt    = (state == DONE);
    result_nxt = result_q;
    exc_nxt    = exc_q;
    if (state == DONE) begin
      if (!is_div) begin
        result_nxt = sprod[WIDTH-1:0];
        exc_nxt    = !((&prod_hi) || !(|prod_hi));
      end else if (div_zero) begin
        result_nxt = '0;
        exc_nxt    = 1'b1;
      end else begin
        result_nxt = neg ? -lo : lo;
        exc_nxt    = !neg && lo[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
    end else begin
      busy_q   <= busy_nxt;
      rdy_q    <= rdy_nxt;
      exc_q    <= exc_nxt;
      result_q <= result_nxt;
    end
  end

  // Datapath: acc holds product high half / partial remainder, lo holds multiplier / quotient.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      lo       <= '0;
      mcand    <= '0;
      neg      <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (start_mul || start_div) begin
      cnt      <= '0;
      acc      <= '0;
      lo       <= start_mul ? b_mag : a_mag;
      mcand    <= start_mul ? a_mag : b_mag;
      neg      <= mdu.data_operandA[WIDTH-1] ^ mdu.data_operandB[WIDTH-1];
      is_div   <= start_div;
      div_zero <= start_div && (mdu.data_operandB == '0);
    end else if (state == MULT) begin
      acc <= mul_sum[WIDTH:1];
      lo  <= {mul_sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end else if (state == DIV) begin
      if (!div_diff[WIDTH]) begin
        acc <= div_diff[WIDTH-1:0];
        lo  <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc <= rem_shift[WIDTH-1:0];
        lo  <= {lo[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt + 1'b1;
    end else if (state == DONE) begin
      cnt <= '0;
    end
  end

  assign mdu.busy           = busy_q;
  assign mdu.data_resultRDY = rdy_q;
  assign mdu.data_exception = exc_q;
  assign mdu.data_result    = result_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, busy window, results/exceptions, start filtering, async reset.
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  multdiv_unit_if #(.WIDTH(32)) mdu ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .mdu   (mdu.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start edge is edge 0; cycle k is sampled #1 after edge k. Optional ignored DIV 9/3 pulsed at cycle inj.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int rdy_cyc, output int rdy_cnt,
                        output int busy_first, output int busy_last, output int busy_cnt);
    rdy_cyc = -1; rdy_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    @(negedge clock);
    mdu.data_operandA = a; mdu.data_operandB = b;
    mdu.ctrl_MULT = m; mdu.ctrl_DIV = d;
    @(posedge clock); #1;
    mdu.ctrl_MULT = 1'b0; mdu.ctrl_DIV = 1'b0;
    mdu.data_operandA = 32'hDEAD_BEEF; mdu.data_operandB = 32'h0000_0005;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
      end
      if (mdu.data_resultRDY) begin
        rdy_cnt++;
        if (rdy_cyc < 0) rdy_cyc = k;
      end
      if (mdu.busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = k;
        busy_last = k;
      end
      if (k == inj) begin
        mdu.data_operandA = 32'd9; mdu.data_operandB = 32'd3; mdu.ctrl_DIV = 1'b1;
      end else if (k == inj + 1) begin
        mdu.ctrl_DIV = 1'b0;
      end
    end
  endtask

  int rc, rn, bf, bl, bn;

  initial begin
    mdu.data_operandA = '0; mdu.data_operandB = '0;
    mdu.ctrl_MULT = 1'b0; mdu.ctrl_DIV = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("reset_result", mdu.data_result, 32'h0);
    check("reset_exc", {31'b0, mdu.data_exception}, 32'h0);
    check("reset_rdy", {31'b0, mdu.data_resultRDY}, 32'h0);
    check("reset_busy", {31'b0, mdu.busy}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -5, rc, rn, bf, bl, bn);
    check("mul7x-3_rdy_cycle", rc, 33);
    check("mul7x-3_rdy_count", rn, 1);
    check("mul7x-3_busy_first", bf, 1);
    check("mul7x-3_busy_last", bl, 32);
    check("mul7x-3_busy_count", bn, 32);
    check("mul7x-3_result", mdu.data_result, 32'hFFFF_FFEB);
    check("mul7x-3_exc", {31'b0, mdu.data_exception}, 32'h0);

    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, -5, rc, rn, bf, bl, bn);
    check("mul_ovf_result", mdu.data_result, 32'h0);
    check("mul_ovf_exc", {31'b0, mdu.data_exception}, 32'h1);

    run_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, -5, rc, rn, bf, bl, bn);
    check("mul_min_result", mdu.data_result, 32'h8000_0000);
    check("mul_min_exc", {31'b0, mdu.data_exception}, 32'h0);

    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -5, rc, rn, bf, bl, bn);
    check("div-7/2_rdy_cycle", rc, 33);
    check("div-7/2_result", mdu.data_result, 32'hFFFF_FFFD);
    check("div-7/2_exc", {31'b0, mdu.data_exception}, 32'h0);

    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, -5, rc, rn, bf, bl, bn);
    check("div100/-10_result", mdu.data_result, 32'hFFFF_FFF6);
    check("div100/-10_exc", {31'b0, mdu.data_exception}, 32'h0);

    run_op(1'b0, 1'b1, 32'd5, 32'd0, -5, rc, rn, bf, bl, bn);
    check("div0_rdy_cycle", rc, 1);
    check("div0_rdy_count", rn, 1);
    check("div0_busy_count", bn, 0);
    check("div0_result", mdu.data_result, 32'h0);
    check("div0_exc", {31'b0, mdu.data_exception}, 32'h1);

    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -5, rc, rn, bf, bl, bn);
    check("divovf_rdy_cycle", rc, 33);
    check("divovf_result", mdu.data_result, 32'h8000_0000);
    check("divovf_exc", {31'b0, mdu.data_exception}, 32'h1);

    run_op(1'b1, 1'b0, 32'd3, 32'd4, 10, rc, rn, bf, bl, bn);
    check("ignore_div_rdy_cycle", rc, 33);
    check("ignore_div_rdy_count", rn, 1);
    check("ignore_div_result", mdu.data_result, 32'd12);

    run_op(1'b1, 1'b1, 32'd6, 32'd2, -5, rc, rn, bf, bl, bn);
    check("both_rdy_cycle", rc, 33);
    check("both_result", mdu.data_result, 32'd12);
    check("both_exc", {31'b0, mdu.data_exception}, 32'h0);

    // Asynchronous reset between edges in the middle of a multiply.
    @(negedge clock);
    mdu.data_operandA = 32'd3; mdu.data_operandB = 32'd4; mdu.ctrl_MULT = 1'b1;
    @(posedge clock); #1 mdu.ctrl_MULT = 1'b0;
    repeat (10) @(posedge clock);
    #1 check("midop_busy", {31'b0, mdu.busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midrst_result", mdu.data_result, 32'h0);
    check("midrst_exc", {31'b0, mdu.data_exception}, 32'h0);
    check("midrst_rdy", {31'b0, mdu.data_resultRDY}, 32'h0);
    check("midrst_busy", {31'b0, mdu.busy}, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    rn = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (mdu.data_resultRDY || mdu.busy) rn++;
    end
    check("midrst_no_activity", rn, 0);

    run_op(1'b1, 1'b0, 32'd3, 32'd4, -5, rc, rn, bf, bl, bn);
    check("after_rst_rdy_cycle", rc, 33);
    check("after_rst_result", mdu.data_result, 32'd12);
    check("hold_rdy_low", {31'b0, mdu.data_resultRDY}, 32'h0);
    repeat (3) @(posedge clock);
    #1 check("hold_result", mdu.data_result, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
